// File: rtl/memory_pkg.sv
// Shared encodings for the synchronous memory bank: FSM states and access opcodes.
package memory_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// Plain storage array: one byte-masked write port and a registered read port, no reset.
module memory_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : memory_array

// File: rtl/memory_sync_bank.sv
// Synchronous RAM bank with registered read, byte-masked writes, range/busy error
// reporting and a hardware clear sweep that runs after reset and on request.
module memory_sync_bank
    import memory_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chip_en,
    input  logic                    read_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    busy,
    output logic                    access_err
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_W  = CW'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  data_valid_q;
    logic                  access_err_q;
    logic                  rd_seen_q;

    logic                  in_range_c;
    logic                  accept_c;
    logic                  reject_c;

    logic                  arr_we;
    logic [NB-1:0]         arr_be;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  arr_re;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign busy       = (state_q == ST_CLEAR);
    assign in_range_c = ({1'b0, address} < DEPTH_W);
    assign accept_c   = chip_en && !busy && in_range_c;
    assign reject_c   = chip_en && !accept_c;

    // Next-state logic and write-port muxing: the sweep owns the port while clearing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        arr_we     = 1'b0;
        arr_be     = '0;
        arr_addr   = address;
        arr_wdata  = data_in;
        arr_re     = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                arr_we     = 1'b1;
                arr_be     = '1;
                arr_addr   = clr_addr_q;
                arr_wdata  = CLEAR_VALUE;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if ({1'b0, clr_addr_q} == LAST_W) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept_c) begin
                    arr_we = (read_write == OP_WRITE);
                    arr_be = byte_en;
                    arr_re = (read_write == OP_READ);
                end
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            data_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            rd_seen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            data_valid_q <= arr_re;
            access_err_q <= reject_c;
            if (arr_re) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    memory_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .be   (arr_be),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .re   (arr_re),
        .rdata(arr_rdata)
    );

    // The array read register has no reset; hide it until the first accepted read.
    assign data_out   = rd_seen_q ? arr_rdata : '0;
    assign data_valid = data_valid_q;
    assign access_err = access_err_q;

endmodule : memory_sync_bank

// File: tb/tb_memory_sync_bank.sv
// Directed bench: an 8-bit/256-word bank and a 32-bit/200-word bank driven in lockstep.
module tb_memory_sync_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chip_en;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        clear_req;

    logic [7:0]  data_a;
    logic        valid_a, busy_a, err_a;
    logic [31:0] data_b;
    logic        valid_b, busy_b, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_sync_bank #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .CLEAR_VALUE(8'h00)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .chip_en(chip_en), .read_write(rw),
        .address(addr), .data_in(din[7:0]), .byte_en(be[0:0]), .clear_req(clear_req),
        .data_out(data_a), .data_valid(valid_a), .busy(busy_a), .access_err(err_a)
    );

    memory_sync_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_VALUE(32'h0)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .chip_en(chip_en), .read_write(rw),
        .address(addr), .data_in(din), .byte_en(be), .clear_req(clear_req),
        .data_out(data_b), .data_valid(valid_b), .busy(busy_b), .access_err(err_b)
    );

    typedef struct {
        logic        ce;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        va;
        logic        ea;
        logic [7:0]  da;
        logic        vb;
        logic        eb;
        logic [31:0] db;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ce_, logic rw_, logic [7:0] a_, logic [31:0] d_,
                                logic [3:0] be_, logic va_, logic ea_, logic [7:0] da_,
                                logic vb_, logic eb_, logic [31:0] db_);
        vec_t v;
        v.ce = ce_; v.rw = rw_; v.addr = a_; v.din = d_; v.be = be_;
        v.va = va_; v.ea = ea_; v.da = da_; v.vb = vb_; v.eb = eb_; v.db = db_;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ce_, input logic rw_, input logic [7:0] a_,
                         input logic [31:0] d_, input logic [3:0] be_, input logic clr_);
        @(negedge clk);
        chip_en = ce_; rw = rw_; addr = a_; din = d_; be = be_; clear_req = clr_;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles from index `start`; records the first index at which each busy is low.
    task automatic count_busy(input int start, input int clr_at, output int fa, output int fb);
        fa = -1;
        fb = -1;
        for (int k = start; k <= 300; k++) begin
            @(negedge clk);
            chip_en   = 1'b0;
            clear_req = (k == clr_at);
            @(posedge clk);
            #1;
            if (fa < 0 && !busy_a) fa = k;
            if (fb < 0 && !busy_b) fb = k;
        end
        clear_req = 1'b0;
    endtask

    initial begin
        int fa, fb;
        reset_n = 1'b0; chip_en = 1'b0; rw = 1'b0; addr = '0; din = '0; be = '0;
        clear_req = 1'b0;

        //              ce rw addr   din           be     va ea da     vb eb db
        vecs.push_back(mk(1, 0, 8'd0,   32'h0,        4'h0, 1, 0, 8'h00, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'd17,  32'h0,        4'h0, 1, 0, 8'h00, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'd255, 32'h0,        4'h0, 1, 0, 8'h00, 0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 8'h10,  32'h000000A5, 4'h1, 0, 0, 8'h00, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h10,  32'h0,        4'h0, 1, 0, 8'hA5, 1, 0, 32'h000000A5));
        vecs.push_back(mk(1, 1, 8'h11,  32'h0000003C, 4'h1, 0, 0, 8'hA5, 0, 0, 32'h000000A5));
        vecs.push_back(mk(1, 0, 8'h11,  32'h0,        4'h0, 1, 0, 8'h3C, 1, 0, 32'h0000003C));
        vecs.push_back(mk(1, 1, 8'h20,  32'hDEADBEEF, 4'hF, 0, 0, 8'h3C, 0, 0, 32'h0000003C));
        vecs.push_back(mk(1, 1, 8'h20,  32'h00000011, 4'h1, 0, 0, 8'h3C, 0, 0, 32'h0000003C));
        vecs.push_back(mk(1, 0, 8'h20,  32'h0,        4'h0, 1, 0, 8'h11, 1, 0, 32'hDEADBE11));
        vecs.push_back(mk(1, 1, 8'h20,  32'hFFFFFFFF, 4'h0, 0, 0, 8'h11, 0, 0, 32'hDEADBE11));
        vecs.push_back(mk(1, 0, 8'h20,  32'h0,        4'h0, 1, 0, 8'h11, 1, 0, 32'hDEADBE11));
        vecs.push_back(mk(1, 1, 8'd200, 32'h00000055, 4'h1, 0, 0, 8'h11, 0, 1, 32'hDEADBE11));
        vecs.push_back(mk(1, 0, 8'd199, 32'h0,        4'h0, 1, 0, 8'h00, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'd200, 32'h0,        4'h0, 1, 0, 8'h55, 0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 8'h30,  32'h12345678, 4'h6, 0, 0, 8'h55, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 8'h30,  32'h0,        4'h0, 1, 0, 8'h00, 1, 0, 32'h00345600));
        vecs.push_back(mk(0, 1'bx, 8'hxx, 32'h0,      4'h0, 0, 0, 8'h00, 0, 0, 32'h00345600));

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a",  32'(busy_a),  32'd1);
        chk("rst_busy_b",  32'(busy_b),  32'd1);
        chk("rst_data_a",  32'(data_a),  32'h0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_err_a",   32'(err_a),   32'd0);
        reset_n = 1'b1;

        // Initial sweep length
        count_busy(1, 0, fa, fb);
        chk("init_busy_len_a", 32'(fa), 32'd256);
        chk("init_busy_len_b", 32'(fb), 32'd200);

        // Vector table
        foreach (vecs[i]) begin
            apply(vecs[i].ce, vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].be, 1'b0);
            chk($sformatf("v%0d_valid_a", i), 32'(valid_a), 32'(vecs[i].va));
            chk($sformatf("v%0d_err_a", i),   32'(err_a),   32'(vecs[i].ea));
            chk($sformatf("v%0d_data_a", i),  32'(data_a),  32'(vecs[i].da));
            chk($sformatf("v%0d_valid_b", i), 32'(valid_b), 32'(vecs[i].vb));
            chk($sformatf("v%0d_err_b", i),   32'(err_b),   32'(vecs[i].eb));
            chk($sformatf("v%0d_data_b", i),  data_b,       vecs[i].db);
        end

        // Clear request alongside a read: read sees pre-clear data, then sweep
        apply(1, 1, 8'd5, 32'h00000077, 4'h1, 1'b0);
        apply(1, 0, 8'd5, 32'h0, 4'h0, 1'b1);
        chk("clr_rd_data_a",  32'(data_a),  32'h77);
        chk("clr_rd_valid_a", 32'(valid_a), 32'd1);
        chk("clr_rd_data_b",  data_b,       32'h00000077);
        chk("clr_busy_a",     32'(busy_a),  32'd1);
        apply(1, 0, 8'd5, 32'h0, 4'h0, 1'b0);
        chk("busy_rd_err_a",   32'(err_a),   32'd1);
        chk("busy_rd_valid_a", 32'(valid_a), 32'd0);
        chk("busy_rd_data_a",  32'(data_a),  32'h77);
        chk("busy_rd_err_b",   32'(err_b),   32'd1);
        count_busy(2, 50, fa, fb);
        chk("clr_busy_len_a", 32'(fa), 32'd256);
        chk("clr_busy_len_b", 32'(fb), 32'd200);
        apply(1, 0, 8'd5, 32'h0, 4'h0, 1'b0);
        chk("post_clr_data_a",  32'(data_a),  32'h00);
        chk("post_clr_valid_a", 32'(valid_a), 32'd1);
        chk("post_clr_data_b",  data_b,       32'h0);

        // Reset in the middle of a sweep
        apply(1, 1, 8'h20, 32'h00000011, 4'h1, 1'b0);
        apply(1, 0, 8'h20, 32'h0, 4'h0, 1'b0);
        chk("pre_rst_data_a", 32'(data_a), 32'h11);
        apply(0, 0, 8'h0, 32'h0, 4'h0, 1'b1);
        chk("sweep2_busy_a", 32'(busy_a), 32'd1);
        for (int k = 1; k <= 100; k++) apply(0, 0, 8'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy_a", 32'(busy_a), 32'd1);
        chk("mid_rst_data_a", 32'(data_a), 32'h0);
        chk("mid_rst_data_b", data_b,      32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_hold_busy_a", 32'(busy_a), 32'd1);
        reset_n = 1'b1;
        count_busy(1, 10, fa, fb);
        chk("rst_sweep_len_a", 32'(fa), 32'd256);
        chk("rst_sweep_len_b", 32'(fb), 32'd200);
        apply(1, 0, 8'h20, 32'h0, 4'h0, 1'b0);
        chk("final_data_a",  32'(data_a),  32'h00);
        chk("final_valid_a", 32'(valid_a), 32'd1);
        chk("final_data_b",  data_b,       32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_memory_sync_bank
